ddc_edid_hpd_ctrl: RTL and testbench
====================================

Name: ddc_edid_hpd_ctrl

Overview:
- Sequences EDID video-mode changes for the DDC EDID slave path.
- Accepts a requested EDID bank (video mode) and drops HPD. Waits for any in-flight DDC/I2C read to finish, then swaps the ROM bank select.
- Holds HPD low for a programmable time before reasserting it, so the source re-reads a consistent EDID.
- Sits between the mode source (VIO/IR/register) and the EDID ROM bank address/HPD pin; replaces free-running mode-change detection with a handshaked controller.

Parameters:
- HPD_LOW_CYC, 24'd5_000_000, HPD low time in i_local_clk cycles (100 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 24, width of the HPD/timeout counter.
- BUSY_TMO_CYC, 24'd500_000, max cycles to wait for I2C idle (used only with the optional feature).
- INIT_MODE, 4'd0, EDID bank selected out of reset.

Ports:
- i_local_clk  in  1  single clock for all logic.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mode_vld  in  1  mode change request valid.
- i_mode  in  4  requested EDID bank (ROM address bits [11:8]).
- o_mode_rdy  out  1  controller can accept a request this cycle.
- i_i2c_busy  in  1  I2C slave is mid-transaction (not in idle state); same clock domain.
- o_rom_bank  out  4  EDID ROM bank select, registered.
- o_ddc_hpd  out  1  hot-plug detect to connector, registered.
- o_mode_done  out  1  one-cycle pulse when HPD reasserts after a change.
- o_state  out  3  current FSM state, for debug.

Behaviour:
Clock, reset and handshake:
- One clock; reset is asynchronous and active-low (i_local_clk, i_rst_n). All outputs are registered.
- Reset values: o_rom_bank=INIT_MODE, o_ddc_hpd=0, o_mode_rdy=0, o_mode_done=0, state=ST_LOW, counter=0.
- Handshake: a request is accepted on a cycle where i_mode_vld && o_mode_rdy.
- o_mode_rdy=1 only in ST_ON. Requests while not ready are ignored, not queued.
- The source holds i_mode_vld until accepted.

FSM states (o_state encoding):
- ST_ON=0: HPD high, bank stable, o_mode_rdy=1.
  - Accepted request with i_mode==o_rom_bank: stay in ST_ON, pulse o_mode_done next cycle, no HPD toggle.
  - Accepted request with a different mode: latch it into r_pend_mode, o_ddc_hpd<=0, go to ST_DRAIN.
- ST_DRAIN=1: HPD low, wait for i_i2c_busy==0, then go to ST_SWAP.
  - If busy is already 0 on entry, leave after 1 cycle.
- ST_SWAP=2: o_rom_bank<=r_pend_mode, counter<=0, go to ST_LOW.
  - Exactly one cycle in this state.
- ST_LOW=3: counter increments each cycle.
  - When counter==HPD_LOW_CYC-1: o_ddc_hpd<=1, counter<=0, go to ST_ON.
  - o_mode_done pulses in the same cycle HPD rises, except after reset (no pulse on the initial rise).

Latency and invariants:
- Bank never changes while i_i2c_busy=1 or while o_ddc_hpd=1.
- o_ddc_hpd rises exactly HPD_LOW_CYC cycles after o_rom_bank updates.
- Mode-change latency from accept to HPD high = 1 (HPD low) + drain cycles + 1 (swap) + HPD_LOW_CYC.
- Counter saturates at its terminal value and never wraps.

Boundary cases:
- i_i2c_busy toggling during ST_LOW is ignored.
- i_mode_vld held high in ST_ON with a new value is accepted once; a further differing value is accepted only after returning to ST_ON.
- Reset mid-sequence: bank returns to INIT_MODE, HPD drops immediately (asynchronously), the full HPD_LOW_CYC low time is re-run, and any pending mode is discarded.

Optional Feature:
- Macro DDC_EDID_BUSY_TMO_EN.
- Defined: in ST_DRAIN the counter counts while i_i2c_busy=1. On reaching BUSY_TMO_CYC-1 the FSM forces ST_SWAP and sets sticky o_tmo_flag (extra 1-bit output, cleared only by reset).
- Undefined: ST_DRAIN waits indefinitely on i_i2c_busy, and o_tmo_flag is absent from the port list.

Test Plan:
- Reset release (HPD_LOW_CYC=10, INIT_MODE=3) -> o_rom_bank=3, o_ddc_hpd low for 10 cycles then high, o_mode_rdy=1, no o_mode_done pulse.
- In ST_ON, i_mode_vld=1, i_mode=5, i_i2c_busy=0 -> HPD falls next cycle, o_rom_bank=5 two cycles later, HPD high 10 cycles after the bank update, o_mode_done single pulse.
- Request i_mode=5 while bank=5 -> HPD stays 1, o_mode_done pulse, bank unchanged.
- Request i_mode=7 with i_i2c_busy=1 for 20 cycles -> state stays ST_DRAIN, bank stays 5 until busy falls, then swaps to 7.
- Assert i_rst_n=0 during ST_LOW of a change to 9 -> HPD=0 immediately, bank=INIT_MODE, full 10-cycle low time re-run, bank 9 never appears.
- With DDC_EDID_BUSY_TMO_EN and BUSY_TMO_CYC=8, i_i2c_busy stuck at 1 -> swap after 8 drain cycles, o_tmo_flag=1 and stays set.

Source files
------------

// File: rtl/ddc_edid_hpd_ctrl.sv
// EDID bank switch sequencer: drops HPD, drains the DDC slave, swaps the ROM bank, then holds HPD low.
// Optional I2C-busy timeout is compiled in with `define DDC_EDID_BUSY_TMO_EN (adds o_tmo_flag).
module ddc_edid_hpd_ctrl #(
    parameter int unsigned      CNT_W        = 24,
    parameter logic [CNT_W-1:0] HPD_LOW_CYC  = 24'd5_000_000,
    parameter logic [3:0]       INIT_MODE    = 4'd0
`ifdef DDC_EDID_BUSY_TMO_EN
    ,
    parameter logic [CNT_W-1:0] BUSY_TMO_CYC = 24'd500_000
`endif
) (
    input  logic       i_local_clk,
    input  logic       i_rst_n,
    input  logic       i_mode_vld,
    input  logic [3:0] i_mode,
    output logic       o_mode_rdy,
    input  logic       i_i2c_busy,
    output logic [3:0] o_rom_bank,
    output logic       o_ddc_hpd,
    output logic       o_mode_done,
`ifdef DDC_EDID_BUSY_TMO_EN
    output logic       o_tmo_flag,
`endif
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_ON    = 3'd0,
        ST_DRAIN = 3'd1,
        ST_SWAP  = 3'd2,
        ST_LOW   = 3'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(HPD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef DDC_EDID_BUSY_TMO_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO_CYC - 1);
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pend_mode;
    logic             r_boot;       // first HPD rise after reset must not pulse o_mode_done

    assign o_state = r_state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_LOW;
            r_cnt       <= '0;
            r_pend_mode <= 4'd0;
            r_boot      <= 1'b1;
            o_rom_bank  <= INIT_MODE;
            o_ddc_hpd   <= 1'b0;
            o_mode_rdy  <= 1'b0;
            o_mode_done <= 1'b0;
`ifdef DDC_EDID_BUSY_TMO_EN
            o_tmo_flag  <= 1'b0;
`endif
        end else begin
            o_mode_done <= 1'b0;
            case (r_state)
                ST_ON: begin
                    if (i_mode_vld) begin
                        if (i_mode == o_rom_bank) begin
                            o_mode_done <= 1'b1;
                        end else begin
                            r_pend_mode <= i_mode;
                            o_ddc_hpd   <= 1'b0;
                            o_mode_rdy  <= 1'b0;
                            r_cnt       <= '0;
                            r_state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
`ifdef DDC_EDID_BUSY_TMO_EN
                    if (!i_i2c_busy) begin
                        r_state <= ST_SWAP;
                    end else if (r_cnt == TMO_LAST) begin
                        r_state    <= ST_SWAP;
                        o_tmo_flag <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`else
                    if (!i_i2c_busy) begin
                        r_state <= ST_SWAP;
                    end
`endif
                end
                ST_SWAP: begin
                    o_rom_bank <= r_pend_mode;
                    r_cnt      <= '0;
                    r_state    <= ST_LOW;
                end
                ST_LOW: begin
                    if (r_cnt == LOW_LAST) begin
                        o_ddc_hpd   <= 1'b1;
                        o_mode_rdy  <= 1'b1;
                        o_mode_done <= ~r_boot;
                        r_boot      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_ON;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Unused encodings fall back into a full HPD-low period.
                    r_state    <= ST_LOW;
                    r_cnt      <= '0;
                    o_ddc_hpd  <= 1'b0;
                    o_mode_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddc_edid_hpd_ctrl.sv
// Self-checking bench for ddc_edid_hpd_ctrl: vector table, directed corner sequences, random traffic vs event model.
`timescale 1ns/1ps
module tb_ddc_edid_hpd_ctrl;

    localparam int         N    = 10;
    localparam logic [3:0] INIT = 4'd3;
    localparam int         TMO  = 8;

    logic       i_local_clk = 1'b0;
    logic       i_rst_n     = 1'b0;
    logic       i_mode_vld  = 1'b0;
    logic [3:0] i_mode      = 4'd0;
    logic       i_i2c_busy  = 1'b0;
    logic       o_mode_rdy;
    logic [3:0] o_rom_bank;
    logic       o_ddc_hpd;
    logic       o_mode_done;
    logic [2:0] o_state;
`ifdef DDC_EDID_BUSY_TMO_EN
    logic       o_tmo_flag;
`endif

    always #5 i_local_clk = ~i_local_clk;

    ddc_edid_hpd_ctrl #(
        .CNT_W       (24),
        .HPD_LOW_CYC (24'd10),
        .INIT_MODE   (INIT)
`ifdef DDC_EDID_BUSY_TMO_EN
        ,
        .BUSY_TMO_CYC(24'd8)
`endif
    ) dut (
        .i_local_clk (i_local_clk),
        .i_rst_n     (i_rst_n),
        .i_mode_vld  (i_mode_vld),
        .i_mode      (i_mode),
        .o_mode_rdy  (o_mode_rdy),
        .i_i2c_busy  (i_i2c_busy),
        .o_rom_bank  (o_rom_bank),
        .o_ddc_hpd   (o_ddc_hpd),
        .o_mode_done (o_mode_done),
`ifdef DDC_EDID_BUSY_TMO_EN
        .o_tmo_flag  (o_tmo_flag),
`endif
        .o_state     (o_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Event-time reference: each accepted change schedules its swap and HPD rise as absolute edge numbers.
    int         cyc, m_swap_at, m_rise_at, m_drain_cnt;
    logic [3:0] m_bank, m_pend;
    bit         m_hpd, m_rdy, m_done, m_boot, m_draining, m_tmo;

    function void model_reset();
        cyc = 0; m_bank = INIT; m_pend = 4'd0;
        m_hpd = 0; m_rdy = 0; m_done = 0; m_boot = 1; m_tmo = 0;
        m_draining = 0; m_drain_cnt = 0;
        m_swap_at = -1; m_rise_at = N;
    endfunction

    function void model_edge(input bit vld, input logic [3:0] mode, input bit busy);
        bit acc;
        cyc++;
        acc    = vld && m_rdy;
        m_done = 0;
        if (m_draining) begin
            if (!busy) begin
                m_draining = 0; m_swap_at = cyc + 1;
            end
`ifdef DDC_EDID_BUSY_TMO_EN
            else if (m_drain_cnt == TMO - 1) begin
                m_draining = 0; m_swap_at = cyc + 1; m_tmo = 1;
            end else begin
                m_drain_cnt++;
            end
`endif
        end
        if (m_swap_at == cyc) begin
            m_bank = m_pend; m_swap_at = -1; m_rise_at = cyc + N;
        end
        if (m_rise_at == cyc) begin
            m_hpd = 1; m_rdy = 1; m_done = !m_boot; m_boot = 0; m_rise_at = -1;
        end
        if (acc) begin
            if (mode == m_bank) m_done = 1;
            else begin
                m_pend = mode; m_hpd = 0; m_rdy = 0; m_draining = 1; m_drain_cnt = 0;
            end
        end
    endfunction

    function int m_state();
        if (m_rdy)              return 0;
        if (m_draining)         return 1;
        if (m_swap_at != -1)    return 2;
        return 3;
    endfunction

    task automatic cmp_model(input string tag);
        check({tag, ".bank"},  int'(o_rom_bank),  int'(m_bank));
        check({tag, ".hpd"},   int'(o_ddc_hpd),   int'(m_hpd));
        check({tag, ".rdy"},   int'(o_mode_rdy),  int'(m_rdy));
        check({tag, ".done"},  int'(o_mode_done), int'(m_done));
        check({tag, ".state"}, int'(o_state),     m_state());
`ifdef DDC_EDID_BUSY_TMO_EN
        check({tag, ".tmo"},   int'(o_tmo_flag),  int'(m_tmo));
`endif
    endtask

    int t_bank = -1, t_hpd = -1, n_falls = 0;

    // Drive at the falling edge, let the rising edge act, sample at the next falling edge.
    task automatic step(input bit vld, input logic [3:0] mode, input bit busy);
        logic [3:0] prev_bank;
        logic       prev_hpd;
        prev_bank  = o_rom_bank;
        prev_hpd   = o_ddc_hpd;
        i_mode_vld = vld;
        i_mode     = mode;
        i_i2c_busy = busy;
        @(posedge i_local_clk);
        model_edge(vld, mode, busy);
        @(negedge i_local_clk);
        if (o_rom_bank != prev_bank) t_bank = cyc;
        if (o_ddc_hpd && !prev_hpd)  t_hpd = cyc;
        if (!o_ddc_hpd && prev_hpd)  n_falls++;
    endtask

    typedef struct {
        bit         vld;
        logic [3:0] mode;
        bit         busy;
        logic [3:0] bank;
        bit         hpd;
        bit         rdy;
        bit         done;
        logic [2:0] st;
    } vec_t;

    function automatic vec_t mk(input int vld, input int mode, input int busy, input int bank,
                                input int hpd, input int rdy, input int done, input int st);
        vec_t r;
        r.vld = 1'(vld); r.mode = 4'(mode); r.busy = 1'(busy); r.bank = 4'(bank);
        r.hpd = 1'(hpd); r.rdy = 1'(rdy); r.done = 1'(done); r.st = 3'(st);
        return r;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[26];
        bit   vld, busy;
        logic [3:0] mode;
        int   falls0;

        // Row k holds inputs for, and outputs after, rising edge k+1 following reset release.
        for (int i = 0; i < 9; i++) tbl[i] = mk(0, 0, 0, 3, 0, 0, 0, 3);
        tbl[9]  = mk(0, 0, 0, 3, 1, 1, 0, 0);
        tbl[10] = mk(1, 5, 0, 3, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 3, 0, 0, 0, 2);
        for (int i = 12; i < 22; i++) tbl[i] = mk(0, 0, 0, 5, 0, 0, 0, 3);
        tbl[22] = mk(0, 0, 0, 5, 1, 1, 1, 0);
        tbl[23] = mk(0, 0, 0, 5, 1, 1, 0, 0);
        tbl[24] = mk(1, 5, 0, 5, 1, 1, 1, 0);
        tbl[25] = mk(0, 0, 0, 5, 1, 1, 0, 0);

        repeat (2) @(negedge i_local_clk);
        check("rst.bank",  int'(o_rom_bank),  int'(INIT));
        check("rst.hpd",   int'(o_ddc_hpd),   0);
        check("rst.rdy",   int'(o_mode_rdy),  0);
        check("rst.done",  int'(o_mode_done), 0);
        check("rst.state", int'(o_state),     3);
        model_reset();
        i_rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].vld, tbl[i].mode, tbl[i].busy);
            check($sformatf("vec%0d.bank", i),  int'(o_rom_bank),  int'(tbl[i].bank));
            check($sformatf("vec%0d.hpd", i),   int'(o_ddc_hpd),   int'(tbl[i].hpd));
            check($sformatf("vec%0d.rdy", i),   int'(o_mode_rdy),  int'(tbl[i].rdy));
            check($sformatf("vec%0d.done", i),  int'(o_mode_done), int'(tbl[i].done));
            check($sformatf("vec%0d.state", i), int'(o_state),     int'(tbl[i].st));
        end

        // Change to 7 while the I2C slave stays busy for 20 cycles.
        step(1'b1, 4'd7, 1'b1);
        cmp_model("busy_acc");
        for (int i = 0; i < 19; i++) begin
            step(1'b0, 4'd0, 1'b1);
            cmp_model("busy_hold");
        end
`ifdef DDC_EDID_BUSY_TMO_EN
        check("tmo.flag_set", int'(o_tmo_flag), 1);
        check("tmo.bank",     int'(o_rom_bank), 7);
`else
        check("drain.state", int'(o_state),    1);
        check("drain.bank",  int'(o_rom_bank), 5);
`endif
        for (int i = 0; i < 40 && !o_ddc_hpd; i++) begin
            step(1'b0, 4'd0, 1'b0);
            cmp_model("busy_rel");
        end
        check("swap7.bank",     int'(o_rom_bank), 7);
        check("swap7.hpd",      int'(o_ddc_hpd),  1);
        check("hpd_after_bank", t_hpd - t_bank,   N);

        // Reset during the HPD-low period of a change to 9.
        step(1'b1, 4'd9, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0);
        cmp_model("pre_rst");
        i_rst_n = 1'b0;
        #1;
        check("arst.hpd",   int'(o_ddc_hpd),  0);
        check("arst.bank",  int'(o_rom_bank), int'(INIT));
        check("arst.state", int'(o_state),    3);
        model_reset();
        i_rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            step(1'b0, 4'd0, 1'b0);
            cmp_model("rerun");
            check("rerun.no_bank9", int'(o_rom_bank == 4'd9), 0);
        end
        check("rerun.hpd_up",  int'(o_ddc_hpd),   1);
        check("rerun.no_done", int'(o_mode_done), 0);

        // A request held high is taken once; once equal to the bank it only pulses done.
        falls0 = n_falls;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'd6, 1'b0);
            cmp_model("held");
        end
        check("held.one_change", n_falls - falls0, 1);
        check("held.bank",       int'(o_rom_bank), 6);

        // Random traffic: source holds each request until accepted; busy toggles freely.
        vld  = 1'b0;
        mode = 4'd0;
        busy = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bit acc;
            if (!vld && $urandom_range(0, 5) == 0) begin
                vld  = 1'b1;
                mode = ($urandom_range(0, 3) == 0) ? m_bank : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 4) == 0) busy = ~busy;
            acc = vld && m_rdy;
            step(vld, mode, busy);
            cmp_model("rand");
            if (acc) vld = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
